// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: register address, XZR index and hazard FSM states.
package cpu_pipe_pkg;

    typedef logic [4:0] reg_addr_t;

    // XZR reads as zero and is never written, so it can never carry a hazard.
    localparam reg_addr_t ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StBrFlush = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: ID source registers against a load's destination in EX.
module hazard_detect
    import cpu_pipe_pkg::*;
#(
    parameter reg_addr_t ZERO_REG = cpu_pipe_pkg::ZERO_REG
) (
    input  logic      ex_read_enable_i,
    input  logic      ex_reg_write_i,
    input  reg_addr_t ex_rd_addr_i,
    input  reg_addr_t id_rn_addr_i,
    input  reg_addr_t id_rm_addr_i,
    input  logic      id_uses_rn_i,
    input  logic      id_uses_rm_i,
    output logic      lu_hit_o
);

    logic rn_match;
    logic rm_match;

    assign rn_match = id_uses_rn_i && (id_rn_addr_i == ex_rd_addr_i);
    assign rm_match = id_uses_rm_i && (id_rm_addr_i == ex_rd_addr_i);

    assign lu_hit_o = ex_read_enable_i && ex_reg_write_i && (ex_rd_addr_i != ZERO_REG) &&
                      (rn_match || rm_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control for the ID/EX register bank: load-use stalls and taken-branch flushes.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned BR_FLUSH_CYCLES = 1,
    parameter reg_addr_t   ZERO_REG        = cpu_pipe_pkg::ZERO_REG
) (
    input  logic        clk,
    input  logic        reset,
    input  reg_addr_t   id_RnAddr,
    input  reg_addr_t   id_RmAddr,
    input  logic        id_usesRn,
    input  logic        id_usesRm,
    input  reg_addr_t   ex_RdAddr,
    input  logic        ex_read_enable,
    input  logic        ex_RegWrite,
    input  logic        br_taken,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] br_flush_cnt,
`endif
    output logic [1:0]  state_o
);

    // Remaining extra cycles after the detecting/resolving cycle, minus one.
    localparam logic [1:0] LuCntInit = 2'(LU_STALL_CYCLES - 2);
    localparam logic [1:0] BrCntInit = 2'(BR_FLUSH_CYCLES - 2);

    hz_state_t  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu_hit;

    hazard_detect #(
        .ZERO_REG (ZERO_REG)
    ) u_detect (
        .ex_read_enable_i (ex_read_enable),
        .ex_reg_write_i   (ex_RegWrite),
        .ex_rd_addr_i     (ex_RdAddr),
        .id_rn_addr_i     (id_RnAddr),
        .id_rm_addr_i     (id_RmAddr),
        .id_uses_rn_i     (id_usesRn),
        .id_uses_rm_i     (id_usesRm),
        .lu_hit_o         (lu_hit)
    );

    // State and countdown register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and zero-latency control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        unique case (state_q)
            StRun, StLuStall: begin
                // A taken branch outranks any load-use hazard, and aborts a stall in progress.
                if (br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_d = StBrFlush;
                        cnt_d   = BrCntInit;
                    end else begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end
                end else if (state_q == StLuStall) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end else if (lu_hit) begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    if (LU_STALL_CYCLES > 1) begin
                        state_d = StLuStall;
                        cnt_d   = LuCntInit;
                    end
                end
            end
            StBrFlush: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 2'd0;
            end
        endcase
    end

    assign state_o = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] lu_stall_cnt_q;
    logic [31:0] br_flush_cnt_q;

    // Saturating per-cycle counters of stall and flush activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lu_stall_cnt_q <= 32'd0;
            br_flush_cnt_q <= 32'd0;
        end else begin
            if (idex_bubble && pc_hold && (lu_stall_cnt_q != 32'hFFFF_FFFF)) begin
                lu_stall_cnt_q <= lu_stall_cnt_q + 32'd1;
            end
            if (idex_bubble && ifid_flush && (br_flush_cnt_q != 32'hFFFF_FFFF)) begin
                br_flush_cnt_q <= br_flush_cnt_q + 32'd1;
            end
        end
    end

    assign lu_stall_cnt = lu_stall_cnt_q;
    assign br_flush_cnt = br_flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three parameterisations share one stimulus stream.
// Instance a: LU=1 BR=1, instance b: LU=2 BR=3, instance c: LU=1 BR=2.
module tb_hazard_ctrl;

    // Output vector: {pc_hold, ifid_hold, ifid_flush, idex_bubble, state_o[1:0]}
    localparam logic [5:0] O_IDLE  = 6'b0000_00;
    localparam logic [5:0] O_HOLD  = 6'b1101_00;
    localparam logic [5:0] O_FLUSH = 6'b0011_00;
    localparam logic [5:0] S_LU    = 6'd1;
    localparam logic [5:0] S_BR    = 6'd2;

    logic       clk;
    logic       reset;
    logic [4:0] id_RnAddr, id_RmAddr, ex_RdAddr;
    logic       id_usesRn, id_usesRm, ex_read_enable, ex_RegWrite, br_taken;

    logic       pc_hold_a, ifid_hold_a, ifid_flush_a, idex_bubble_a;
    logic       pc_hold_b, ifid_hold_b, ifid_flush_b, idex_bubble_b;
    logic       pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c;
    logic [1:0] state_a, state_b, state_c;
    logic [5:0] o_a, o_b, o_c;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] lu_cnt_a, br_cnt_a, lu_cnt_b, br_cnt_b, lu_cnt_c, br_cnt_c;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    assign o_a = {pc_hold_a, ifid_hold_a, ifid_flush_a, idex_bubble_a, state_a};
    assign o_b = {pc_hold_b, ifid_hold_b, ifid_flush_b, idex_bubble_b, state_b};
    assign o_c = {pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c, state_c};

    hazard_ctrl #(.LU_STALL_CYCLES(1), .BR_FLUSH_CYCLES(1), .ZERO_REG(5'd31)) u_a (
        .clk (clk), .reset (reset),
        .id_RnAddr (id_RnAddr), .id_RmAddr (id_RmAddr),
        .id_usesRn (id_usesRn), .id_usesRm (id_usesRm),
        .ex_RdAddr (ex_RdAddr), .ex_read_enable (ex_read_enable),
        .ex_RegWrite (ex_RegWrite), .br_taken (br_taken),
        .pc_hold (pc_hold_a), .ifid_hold (ifid_hold_a),
        .ifid_flush (ifid_flush_a), .idex_bubble (idex_bubble_a),
`ifdef HAZARD_CTRL_PERF_EN
        .lu_stall_cnt (lu_cnt_a), .br_flush_cnt (br_cnt_a),
`endif
        .state_o (state_a)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(2), .BR_FLUSH_CYCLES(3), .ZERO_REG(5'd31)) u_b (
        .clk (clk), .reset (reset),
        .id_RnAddr (id_RnAddr), .id_RmAddr (id_RmAddr),
        .id_usesRn (id_usesRn), .id_usesRm (id_usesRm),
        .ex_RdAddr (ex_RdAddr), .ex_read_enable (ex_read_enable),
        .ex_RegWrite (ex_RegWrite), .br_taken (br_taken),
        .pc_hold (pc_hold_b), .ifid_hold (ifid_hold_b),
        .ifid_flush (ifid_flush_b), .idex_bubble (idex_bubble_b),
`ifdef HAZARD_CTRL_PERF_EN
        .lu_stall_cnt (lu_cnt_b), .br_flush_cnt (br_cnt_b),
`endif
        .state_o (state_b)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(1), .BR_FLUSH_CYCLES(2), .ZERO_REG(5'd31)) u_c (
        .clk (clk), .reset (reset),
        .id_RnAddr (id_RnAddr), .id_RmAddr (id_RmAddr),
        .id_usesRn (id_usesRn), .id_usesRm (id_usesRm),
        .ex_RdAddr (ex_RdAddr), .ex_read_enable (ex_read_enable),
        .ex_RegWrite (ex_RegWrite), .br_taken (br_taken),
        .pc_hold (pc_hold_c), .ifid_hold (ifid_hold_c),
        .ifid_flush (ifid_flush_c), .idex_bubble (idex_bubble_c),
`ifdef HAZARD_CTRL_PERF_EN
        .lu_stall_cnt (lu_cnt_c), .br_flush_cnt (br_cnt_c),
`endif
        .state_o (state_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drv(input logic re, input logic rw, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic br);
        ex_read_enable = re;
        ex_RegWrite    = rw;
        ex_RdAddr      = rd;
        id_RnAddr      = rn;
        id_RmAddr      = rm;
        id_usesRn      = urn;
        id_usesRm      = urm;
        br_taken       = br;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Called just after a falling edge with inputs applied; checks then moves to next falling edge.
    task automatic cyc(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                       input logic [5:0] ec);
        #1;
        check({tag, "/a"}, {26'd0, o_a}, {26'd0, ea});
        check({tag, "/b"}, {26'd0, o_b}, {26'd0, eb});
        check({tag, "/c"}, {26'd0, o_c}, {26'd0, ec});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        check("rst/a", {26'd0, o_a}, 32'd0);
        check("rst/b", {26'd0, o_b}, 32'd0);
        check("rst/c", {26'd0, o_c}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc("run0", O_IDLE, O_IDLE, O_IDLE);

        // Load-use via Rn.
        drv(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc("lu_rn0", O_HOLD, O_HOLD, O_HOLD);
        idle();
        cyc("lu_rn1", O_IDLE, O_HOLD | S_LU, O_IDLE);
        cyc("lu_rn2", O_IDLE, O_IDLE, O_IDLE);

        // Load-use via Rm (Rn field matches too but is unused).
        drv(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0);
        cyc("lu_rm0", O_HOLD, O_HOLD, O_HOLD);
        idle();
        cyc("lu_rm1", O_IDLE, O_HOLD | S_LU, O_IDLE);

        // Non-hazards.
        drv(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0);
        cyc("xzr", O_IDLE, O_IDLE, O_IDLE);
        drv(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
        cyc("rm_unused", O_IDLE, O_IDLE, O_IDLE);
        drv(1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc("no_regwr", O_IDLE, O_IDLE, O_IDLE);
        drv(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc("no_load", O_IDLE, O_IDLE, O_IDLE);

        // Taken branch pulse.
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("br0", O_FLUSH, O_FLUSH, O_FLUSH);
        idle();
        cyc("br1", O_IDLE, O_FLUSH | S_BR, O_FLUSH | S_BR);
        cyc("br2", O_IDLE, O_FLUSH | S_BR, O_IDLE);
        cyc("br3", O_IDLE, O_IDLE, O_IDLE);

        // Branch and load-use together, then reset during b's second flush cycle.
        drv(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc("brlu0", O_FLUSH, O_FLUSH, O_FLUSH);
        idle();
        #1;
        check("brlu1/b", {26'd0, o_b}, {26'd0, O_FLUSH | S_BR});
        #1 reset = 1'b1;
        #1;
        check("midrst/a", {26'd0, o_a}, 32'd0);
        check("midrst/b", {26'd0, o_b}, 32'd0);
        check("midrst/c", {26'd0, o_c}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc("postrst", O_IDLE, O_IDLE, O_IDLE);

        // Branch while b is in its load-use stall: stall aborts into a flush.
        drv(1'b1, 1'b1, 5'd12, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0);
        cyc("abort0", O_HOLD, O_HOLD, O_HOLD);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc("abort1", O_FLUSH, O_FLUSH | S_LU, O_FLUSH);
        idle();
        cyc("abort2", O_IDLE, O_FLUSH | S_BR, O_FLUSH | S_BR);
        cyc("abort3", O_IDLE, O_FLUSH | S_BR, O_IDLE);
        cyc("abort4", O_IDLE, O_IDLE, O_IDLE);

`ifdef HAZARD_CTRL_PERF_EN
        do_reset();
        #1;
        check("perf_clr_lu", lu_cnt_c, 32'd0);
        check("perf_clr_br", br_cnt_c, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            idle();
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            idle();
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        check("perf_lu/c", lu_cnt_c, 32'd4);
        check("perf_br/c", br_cnt_c, 32'd4);
        check("perf_lu/a", lu_cnt_a, 32'd4);
        check("perf_br/a", br_cnt_a, 32'd2);
        check("perf_lu/b", lu_cnt_b, 32'd8);
        check("perf_br/b", br_cnt_b, 32'd6);
`else
        do_reset();
        cyc("final", O_IDLE, O_IDLE, O_IDLE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
